// File: rtl/serial_word_packer_pkg.sv
// Shared types and constants for the serializer byte-stream word packer.
package serial_word_packer_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WORD_W     = 8 * WORD_BYTES;
    localparam int unsigned ENTRY_W    = WORD_W + WORD_BYTES;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } HTRANS_state;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        FLUSH   = 2'b10,
        DONE    = 2'b11
    } packer_state_t;

    // One FIFO entry: byte enables above the little-endian data word.
    typedef struct packed {
        logic [WORD_BYTES-1:0] strb;
        logic [WORD_W-1:0]     data;
    } word_entry_t;

endpackage

// File: rtl/serial_word_packer_word_fifo.sv
// Small synchronous read-first FIFO holding packed words with their strobes.
module serial_word_packer_word_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 36
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout,
    output logic         o_empty,
    output logic         o_full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_empty;
    logic          r_full;

    logic          w_do_pop;
    logic          w_do_push;
    logic [CW-1:0] w_count_nxt;

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign w_do_pop  = i_pop & ~r_empty;
    assign w_do_push = i_push & (~r_full | w_do_pop);

    // Occupancy after this cycle's push/pop.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage, pointers and registered empty/full flags.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == CW'(DEPTH));
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_empty = r_empty;
    assign o_full  = r_full;

endmodule

// File: rtl/serial_word_packer.sv
// Re-packs the serializer byte stream into 32-bit little-endian words with strobes.
module serial_word_packer
    import serial_word_packer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEN_W      = 16
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_byte_len,
    input  logic [7:0]       i_serialized_output,
    input  logic             i_serialized_output_valid,
    input  logic [1:0]       i_Serialize_Counter,
    output logic [31:0]      o_word,
    output logic [3:0]       o_word_strb,
    output logic             o_word_valid,
    input  logic             i_word_ready,
    output logic [LEN_W-1:0] o_bytes_received,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_lane_error,
    output logic             o_overflow
);

    packer_state_t         r_state, w_state_nxt;
    logic [LEN_W-1:0]      r_len, w_len_nxt;
    logic [LEN_W-1:0]      r_count, w_count_nxt;
    logic [WORD_W-1:0]     r_word, w_word_nxt;
    logic [WORD_BYTES-1:0] r_strb, w_strb_nxt;
    logic [1:0]            r_exp_lane, w_exp_lane_nxt;
    logic                  r_push, w_push_nxt;
    logic                  r_lane_err, w_lane_err_nxt;
    logic                  r_ovf, w_ovf_nxt;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_empty;
    logic                  w_full;
    logic [LEN_W-1:0]      w_count_inc;
    word_entry_t           w_din;
    word_entry_t           w_dout;

    // Completed word is pushed the edge after its last byte; FLUSH pushes the partial word.
    assign w_push      = r_push | (r_state == FLUSH);
    assign w_pop       = ~w_empty & i_word_ready;
    assign w_drop      = w_push & w_full & ~w_pop;
    assign w_count_inc = r_count + LEN_W'(1);
    assign w_din       = '{strb: r_strb, data: r_word};

    // Next-state, packing and flag logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_len_nxt      = r_len;
        w_count_nxt    = r_count;
        w_word_nxt     = w_push ? '0 : r_word;
        w_strb_nxt     = w_push ? '0 : r_strb;
        w_exp_lane_nxt = r_exp_lane;
        w_push_nxt     = 1'b0;
        w_lane_err_nxt = r_lane_err;
        w_ovf_nxt      = r_ovf | w_drop;

        case (r_state)
            IDLE, DONE: begin
                if (i_start) begin
                    w_len_nxt      = i_byte_len;
                    w_count_nxt    = '0;
                    w_exp_lane_nxt = 2'd0;
                    w_lane_err_nxt = 1'b0;
                    w_ovf_nxt      = w_drop;
                    w_state_nxt    = (i_byte_len == '0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if (i_serialized_output_valid) begin
                    for (int unsigned b = 0; b < WORD_BYTES; b++) begin
                        if (i_Serialize_Counter == 2'(b)) begin
                            w_word_nxt[8*b +: 8] = i_serialized_output;
                            w_strb_nxt[b]        = 1'b1;
                        end
                    end
                    if (r_count < r_len) begin
                        w_count_nxt = w_count_inc;
                    end
                    if (i_Serialize_Counter != r_exp_lane) begin
                        w_lane_err_nxt = 1'b1;
                    end
                    w_exp_lane_nxt = i_Serialize_Counter + 2'd1;
                    w_push_nxt     = (i_Serialize_Counter == 2'd3);
                    if (w_count_inc >= r_len) begin
                        w_state_nxt = (i_Serialize_Counter == 2'd3) ? DONE : FLUSH;
                    end
                end
            end
            FLUSH: begin
                w_state_nxt = DONE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers; status outputs registered alongside the state.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_count    <= '0;
            r_word     <= '0;
            r_strb     <= '0;
            r_exp_lane <= 2'd0;
            r_push     <= 1'b0;
            r_lane_err <= 1'b0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_len      <= w_len_nxt;
            r_count    <= w_count_nxt;
            r_word     <= w_word_nxt;
            r_strb     <= w_strb_nxt;
            r_exp_lane <= w_exp_lane_nxt;
            r_push     <= w_push_nxt;
            r_lane_err <= w_lane_err_nxt;
            r_ovf      <= w_ovf_nxt;
            r_busy     <= (w_state_nxt == COLLECT) || (w_state_nxt == FLUSH);
            r_done     <= (w_state_nxt == DONE);
        end
    end

    serial_word_packer_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENTRY_W)
    ) u_word_fifo (
        .i_clk   (HCLK),
        .i_rst   (HRESET),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_din),
        .o_dout  (w_dout),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign o_word           = w_dout.data;
    assign o_word_strb      = w_dout.strb;
    assign o_word_valid     = ~w_empty;
    assign o_bytes_received = r_count;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_lane_error     = r_lane_err;
    assign o_overflow       = r_ovf;

endmodule

// File: tb/tb_serial_word_packer.sv
// Scoreboard bench for serial_word_packer: expected words queued at stimulus time.
module tb_serial_word_packer;

    logic        HCLK;
    logic        HRESET;
    logic        i_start;
    logic [15:0] i_byte_len;
    logic [7:0]  i_ser;
    logic        i_ser_valid;
    logic [1:0]  i_lane;
    logic [31:0] o_word;
    logic [3:0]  o_word_strb;
    logic        o_word_valid;
    logic        i_word_ready;
    logic [15:0] o_bytes_received;
    logic        o_busy;
    logic        o_done;
    logic        o_lane_error;
    logic        o_overflow;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [35:0] exp_q[$];
    logic [35:0] mon_e;

    serial_word_packer #(
        .FIFO_DEPTH (4),
        .LEN_W      (16)
    ) dut (
        .HCLK                      (HCLK),
        .HRESET                    (HRESET),
        .i_start                   (i_start),
        .i_byte_len                (i_byte_len),
        .i_serialized_output       (i_ser),
        .i_serialized_output_valid (i_ser_valid),
        .i_Serialize_Counter       (i_lane),
        .o_word                    (o_word),
        .o_word_strb               (o_word_strb),
        .o_word_valid              (o_word_valid),
        .i_word_ready              (i_word_ready),
        .o_bytes_received          (o_bytes_received),
        .o_busy                    (o_busy),
        .o_done                    (o_done),
        .o_lane_error              (o_lane_error),
        .o_overflow                (o_overflow)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    // Compare the FIFO head against the scoreboard whenever a pop is about to happen.
    always @(negedge HCLK) begin
        if (!HRESET && o_word_valid && i_word_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_word", 64'(exp_q.size()), 64'd1);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("word_data", 64'(o_word), 64'(mon_e[31:0]));
                check_eq("word_strb", 64'(o_word_strb), 64'(mon_e[35:32]));
            end
        end
    end

    task automatic do_start(input logic [15:0] len);
        i_byte_len = len;
        i_start    = 1'b1;
        @(posedge HCLK);
        #1 i_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [1:0] lane);
        i_ser       = b;
        i_lane      = lane;
        i_ser_valid = 1'b1;
        @(posedge HCLK);
        #1 i_ser_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!o_done && k < 200) begin
            @(posedge HCLK);
            #1;
            k++;
        end
        check_eq(tag, 64'(o_done), 64'd1);
    endtask

    task automatic drain(input string tag);
        i_word_ready = 1'b1;
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge HCLK);
        repeat (2) @(posedge HCLK);
        #1;
        check_eq(tag, 64'(exp_q.size()), 64'd0);
        check_eq({tag, "_empty"}, 64'(o_word_valid), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESET       = 1'b1;
        i_start      = 1'b0;
        i_byte_len   = '0;
        i_ser        = '0;
        i_ser_valid  = 1'b0;
        i_lane       = '0;
        i_word_ready = 1'b0;
        repeat (3) @(posedge HCLK);
        #1 HRESET = 1'b0;

        // Reset state
        check_eq("rst_valid", 64'(o_word_valid), 64'd0);
        check_eq("rst_word", 64'(o_word), 64'd0);
        check_eq("rst_strb", 64'(o_word_strb), 64'd0);
        check_eq("rst_busy", 64'(o_busy), 64'd0);
        check_eq("rst_done", 64'(o_done), 64'd0);
        check_eq("rst_count", 64'(o_bytes_received), 64'd0);
        check_eq("rst_lane_err", 64'(o_lane_error), 64'd0);
        check_eq("rst_ovf", 64'(o_overflow), 64'd0);

        // Stray bytes in IDLE are ignored
        send_byte(8'hAA, 2'd0);
        send_byte(8'hBB, 2'd1);
        repeat (2) @(posedge HCLK);
        #1;
        check_eq("idle_stray_count", 64'(o_bytes_received), 64'd0);
        check_eq("idle_stray_valid", 64'(o_word_valid), 64'd0);

        // Nominal packing, len=8
        i_word_ready = 1'b1;
        exp_q.push_back({4'hF, 32'h44332211});
        exp_q.push_back({4'hF, 32'h88776655});
        do_start(16'd8);
        check_eq("nom_busy", 64'(o_busy), 64'd1);
        for (int i = 0; i < 8; i++) begin
            send_byte(8'((i + 1) * 17), 2'(i));
            if (i == 4) check_eq("nom_count_mid", 64'(o_bytes_received), 64'd5);
        end
        wait_done("nom_done");
        check_eq("nom_count", 64'(o_bytes_received), 64'd8);
        check_eq("nom_lane_err", 64'(o_lane_error), 64'd0);
        drain("nom_drain");

        // Partial flush, len=6
        exp_q.push_back({4'hF, 32'h44332211});
        exp_q.push_back({4'h3, 32'h00006655});
        do_start(16'd6);
        for (int i = 0; i < 6; i++) send_byte(8'((i + 1) * 17), 2'(i));
        check_eq("flush_busy", 64'(o_busy), 64'd1);
        check_eq("flush_not_done", 64'(o_done), 64'd0);
        @(posedge HCLK);
        #1;
        check_eq("flush_done", 64'(o_done), 64'd1);
        check_eq("flush_busy_off", 64'(o_busy), 64'd0);
        check_eq("flush_count", 64'(o_bytes_received), 64'd6);
        drain("flush_drain");

        // Lane-order error and two-edge latency
        i_word_ready = 1'b0;
        exp_q.push_back({4'hF, 32'hD4B2C3A1});
        do_start(16'd4);
        send_byte(8'hA1, 2'd0);
        send_byte(8'hB2, 2'd2);
        send_byte(8'hC3, 2'd1);
        send_byte(8'hD4, 2'd3);
        check_eq("lat_edge1_valid", 64'(o_word_valid), 64'd0);
        @(posedge HCLK);
        #1;
        check_eq("lat_edge2_valid", 64'(o_word_valid), 64'd1);
        check_eq("lat_word", 64'(o_word), 64'hD4B2C3A1);
        check_eq("lat_strb", 64'(o_word_strb), 64'hF);
        check_eq("lane_err_set", 64'(o_lane_error), 64'd1);
        wait_done("lane_done");
        drain("lane_drain");

        // Zero length: start clears lane error, DONE next cycle, no push
        do_start(16'd0);
        check_eq("lane_err_cleared", 64'(o_lane_error), 64'd0);
        check_eq("zero_done", 64'(o_done), 64'd1);
        check_eq("zero_busy", 64'(o_busy), 64'd0);
        for (int i = 0; i < 3; i++) send_byte(8'(8'h50 + i), 2'(i));
        repeat (2) @(posedge HCLK);
        #1;
        check_eq("done_stray_count", 64'(o_bytes_received), 64'd0);
        check_eq("done_stray_valid", 64'(o_word_valid), 64'd0);
        check_eq("done_stray_lane_err", 64'(o_lane_error), 64'd0);

        // Backpressure: 5 words into a 4-deep FIFO, fifth dropped
        i_word_ready = 1'b0;
        for (int k = 0; k < 4; k++)
            exp_q.push_back({4'hF, 8'(4*k + 4), 8'(4*k + 3), 8'(4*k + 2), 8'(4*k + 1)});
        do_start(16'd20);
        for (int i = 0; i < 20; i++) send_byte(8'(i + 1), 2'(i));
        wait_done("ovf_done");
        repeat (2) @(posedge HCLK);
        #1;
        check_eq("ovf_flag", 64'(o_overflow), 64'd1);
        check_eq("ovf_count", 64'(o_bytes_received), 64'd20);
        check_eq("ovf_head_valid", 64'(o_word_valid), 64'd1);
        drain("ovf_drain");

        // Push and pop together on a full FIFO: no overflow
        i_word_ready = 1'b0;
        do_start(16'd16);
        check_eq("ovf_cleared", 64'(o_overflow), 64'd0);
        for (int k = 0; k < 4; k++)
            exp_q.push_back({4'hF, 8'(4*k + 4), 8'(4*k + 3), 8'(4*k + 2), 8'(4*k + 1)});
        for (int i = 0; i < 16; i++) send_byte(8'(i + 1), 2'(i));
        wait_done("full_done");
        repeat (2) @(posedge HCLK);
        #1;
        check_eq("full_no_ovf", 64'(o_overflow), 64'd0);
        exp_q.push_back({4'hF, 32'hC4C3C2C1});
        do_start(16'd4);
        send_byte(8'hC1, 2'd0);
        send_byte(8'hC2, 2'd1);
        send_byte(8'hC3, 2'd2);
        send_byte(8'hC4, 2'd3);
        i_word_ready = 1'b1;
        @(posedge HCLK);
        #1;
        check_eq("pushpop_no_ovf", 64'(o_overflow), 64'd0);
        wait_done("pushpop_done");
        drain("pushpop_drain");
        check_eq("pushpop_no_ovf_end", 64'(o_overflow), 64'd0);

        // Asynchronous reset mid-transfer
        i_word_ready = 1'b1;
        do_start(16'd8);
        send_byte(8'h01, 2'd0);
        send_byte(8'h02, 2'd1);
        #2 HRESET = 1'b1;
        #1;
        check_eq("arst_busy", 64'(o_busy), 64'd0);
        check_eq("arst_count", 64'(o_bytes_received), 64'd0);
        check_eq("arst_valid", 64'(o_word_valid), 64'd0);
        check_eq("arst_done", 64'(o_done), 64'd0);
        @(posedge HCLK);
        #1 HRESET = 1'b0;
        exp_q.push_back({4'hF, 32'h4D3C2B1A});
        do_start(16'd4);
        send_byte(8'h1A, 2'd0);
        send_byte(8'h2B, 2'd1);
        send_byte(8'h3C, 2'd2);
        send_byte(8'h4D, 2'd3);
        wait_done("restart_done");
        drain("restart_drain");
        check_eq("restart_count", 64'(o_bytes_received), 64'd4);
        check_eq("restart_lane_err", 64'(o_lane_error), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_word_packer.md
Name: serial_word_packer

Overview:
- Downstream consumer of the CoreSystem serializer. Takes the byte stream (serialized_output / valid / Serialize_Counter) and re-packs it into 32-bit little-endian words with byte strobes.
- Words are buffered in a small FIFO and presented on a valid/ready interface to the checking/monitor side.
- Tracks received bytes against an expected length, flushes a partial final word, and flags lane-order errors and FIFO overflow.

Parameters:
- FIFO_DEPTH, 4, number of 32-bit word entries; power of two, ≥2.
- LEN_W, 16, width of the byte-length and byte-count fields.

Ports:
- HCLK  in  1  clock; all logic on its rising edge.
- HRESET  in  1  asynchronous active-high reset.
- i_start  in  1  one-cycle pulse; latches i_byte_len and starts a transfer. Honoured only in IDLE or DONE.
- i_byte_len  in  LEN_W  expected number of bytes in the transfer.
- i_serialized_output  in  8  incoming byte.
- i_serialized_output_valid  in  1  byte qualifier.
- i_Serialize_Counter  in  2  byte lane of the incoming byte (0..3).
- o_word  out  32  FIFO head data.
- o_word_strb  out  4  FIFO head byte enables.
- o_word_valid  out  1  FIFO not empty.
- i_word_ready  in  1  consumer accept; a pop occurs when o_word_valid && i_word_ready.
- o_bytes_received  out  LEN_W  bytes accepted in the current transfer.
- o_busy  out  1  state is COLLECT or FLUSH.
- o_done  out  1  high while in DONE.
- o_lane_error  out  1  sticky; cleared by i_start.
- o_overflow  out  1  sticky; cleared by i_start.

Behaviour:
Reset values:
- All outputs 0; state IDLE; FIFO empty; packing register, strobe register and expected lane all 0.

States: IDLE, COLLECT, FLUSH, DONE.
- IDLE/DONE + i_start:
  - Latch len, clear byte count, expected lane (0) and sticky flags.
  - Go to DONE if len==0, otherwise COLLECT.
- COLLECT, on each valid byte:
  - Write the byte to bits [8*lane+7 : 8*lane], where lane = i_Serialize_Counter.
  - Set strb[lane].
  - Increment the byte count.
  - If lane != expected lane, set o_lane_error; the byte is still stored at the received lane.
  - Expected lane becomes lane+1 (mod 4).
- Word push from COLLECT:
  - When lane==3, push {word, strb} into the FIFO on the next edge, then clear the packing and strobe registers.
  - If that byte also brings the count to len, go to DONE.
- Length reached on a lane other than 3: go to FLUSH.
- FLUSH:
  - Push the partial word next cycle; unused lanes are 0 with strb bit 0.
  - Then go to DONE. FLUSH lasts exactly 1 cycle.
- DONE: holds until i_start. FIFO contents remain and keep draining.

Valid-byte handling:
- Valid bytes in IDLE, FLUSH or DONE are ignored. They do not change the count or flags.

Latency:
- A byte completing a word appears on o_word with o_word_valid at most 2 edges after the byte's valid cycle: 1 edge into the packing stage, 1 edge into the FIFO.
- The FIFO head is registered, so there is no combinational path from input to o_word.

FIFO:
- Synchronous, read-first.
- Simultaneous push and pop when full is legal: count is unchanged and no overflow.
- Push when full with no pop: the word is dropped and o_overflow is set. Packing continues.
- Pop when empty is a no-op.

Count arithmetic:
- o_bytes_received saturates at len.
- Bytes beyond len cannot occur, since the block leaves COLLECT.

Reset mid-transfer:
- Immediate return to IDLE; FIFO is flushed; partial word is discarded.

Decomposition:
- Shared package, alongside HTRANS_state:
  - packer_state_t enum {IDLE, COLLECT, FLUSH, DONE}.
  - Constant WORD_BYTES = 4.
- One natural sub-module: word_fifo.
  - Parameters DEPTH and W = 36 (data + strb).
  - Ports: push, pop, din, dout, empty, full.
- Packing FSM and counters stay in the top module.

Test Plan:
- Nominal packing: start with len=8; send bytes 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88 on lanes 0..3,0..3; ready held high -> two words 0x44332211 and 0x88776655, each with strb=4'hF; o_done=1; bytes_received=8.
- Partial flush: len=6 -> second word is 0x00006655 with strb=4'h3; FLUSH lasts exactly 1 cycle; then DONE.
- Backpressure/overflow: FIFO_DEPTH=4, ready=0, len=20 -> the first 4 words are held, the 5th is dropped, o_overflow=1. With ready=1 and simultaneous push/pop on full -> no overflow.
- Lane error: len=4, lanes 0,2,1,3 -> o_lane_error=1; the word is still pushed with strb=4'hF. A following i_start clears the flag.
- Zero length and stray bytes: len=0 -> DONE next cycle with no push. Bytes sent in IDLE/DONE -> count stays 0 and o_word_valid stays 0.
- Async reset mid-transfer: assert HRESET after 2 bytes, between clock edges -> outputs go to 0 immediately. After release and a restart with len=4 -> a clean single word.
